// File: rtl/regwrite_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regwrite_port_arbiter
//  Purpose  : Shares the register-file write port among five write-back
//             sources. Source 4 has fixed priority; sources 0..3 are served
//             round-robin, one transaction at a time.
//  Option   : REGWRITE_ZERO_FILTER_EN - suppresses reg_write while wr_addr==0
//  Revision : 1.0 - initial release
// ============================================================================
module regwrite_port_arbiter #(
    parameter int WRITE_CYCLES = 1,
    parameter int CNT_W        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] req,
    input  logic [4:0] wr_addr,
    output logic [2:0] sel,
    output logic       reg_write,
    output logic [4:0] grant,
    output logic       busy
);

    localparam logic [1:0]       S_IDLE     = 2'd0;
    localparam logic [1:0]       S_WRITE    = 2'd1;
    localparam logic [1:0]       S_RELEASE  = 2'd2;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WRITE_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [4:0]       grant_q, grant_d;
    logic             rw_q, rw_d;
    logic [1:0]       rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       prev_q, prev_d;
    logic [4:0]       w_arb_req;
    logic [2:0]       w_win;

    function automatic logic [4:0] f_onehot(input logic [2:0] idx);
        return 5'b00001 << idx;
    endfunction

    // Source 4 first, then the first set bit at or above ptr, wrapping 3->0.
    function automatic logic [2:0] f_arbitrate(input logic [4:0] r, input logic [1:0] ptr);
        logic [2:0] win;
        logic       found;
        logic [1:0] idx;
        win   = 3'd0;
        found = 1'b0;
        if (r[4]) begin
            win = 3'd4;
        end else begin
            for (int i = 0; i < 4; i++) begin
                idx = ptr + 2'(i);
                if (!found && r[idx]) begin
                    win   = {1'b0, idx};
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sel_q   <= 3'd0;
            grant_q <= 5'd0;
            rw_q    <= 1'b0;
            rr_q    <= 2'd0;
            cnt_q   <= '0;
            prev_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            rw_q    <= rw_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        rw_d      = rw_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        prev_d    = prev_q;
        w_arb_req = 5'd0;
        case (state_q)
            S_IDLE: begin
                w_arb_req = req;
            end
            S_WRITE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_RELEASE;
                    grant_d = 5'd0;
                    rw_d    = 1'b0;
                    prev_d  = sel_q;
                    if (sel_q != 3'd4) begin
                        rr_d = sel_q[1:0] + 2'd1;
                    end
                end
            end
            S_RELEASE: begin
                // The source just served is masked so a slow requester is not re-granted.
                w_arb_req = req & ~f_onehot(prev_q);
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        w_win = f_arbitrate(w_arb_req, rr_q);
        if (w_arb_req != 5'd0) begin
            state_d = S_WRITE;
            sel_d   = w_win;
            grant_d = f_onehot(w_win);
            rw_d    = 1'b1;
            cnt_d   = C_CNT_LOAD;
        end
    end

    always_comb begin
        busy = (state_q != S_IDLE);
`ifdef REGWRITE_ZERO_FILTER_EN
        reg_write = rw_q & (wr_addr != 5'd0);
`else
        reg_write = rw_q;
`endif
    end

`ifndef REGWRITE_ZERO_FILTER_EN
    logic w_unused_addr;
    assign w_unused_addr = ^wr_addr;
`endif

    assign sel   = sel_q;
    assign grant = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_regwrite_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regwrite_port_arbiter
//  Purpose  : Two arbiters (WRITE_CYCLES 1 and 3) checked cycle by cycle
//             against a transaction-level model, plus directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regwrite_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] req;
    logic [4:0] wr_addr;
    logic [2:0] sel_a, sel_b;
    logic       rw_a, rw_b;
    logic [4:0] grant_a, grant_b;
    logic       busy_a, busy_b;

    regwrite_port_arbiter #(.WRITE_CYCLES(1), .CNT_W(3)) u_dut_a (
        .clk(clk), .reset(reset), .req(req), .wr_addr(wr_addr),
        .sel(sel_a), .reg_write(rw_a), .grant(grant_a), .busy(busy_a)
    );

    regwrite_port_arbiter #(.WRITE_CYCLES(3), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .req(req), .wr_addr(wr_addr),
        .sel(sel_b), .reg_write(rw_b), .grant(grant_b), .busy(busy_b)
    );

`ifdef REGWRITE_ZERO_FILTER_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Model: current writer (-1 none), write cycles left, gap flag, pointer, last winner, select
    int m_src[2]  = '{-1, -1};
    int m_left[2] = '{0, 0};
    bit m_gap[2]  = '{1'b0, 1'b0};
    int m_rr[2]   = '{0, 0};
    int m_prev[2] = '{0, 0};
    int m_sel[2]  = '{0, 0};
    int wc[2]     = '{1, 3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [4:0] r, input int rr);
        if (r[4]) return 4;
        for (int i = 0; i < 4; i++) begin
            if (r[(rr + i) % 4]) return (rr + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input int k);
        logic [4:0] r;
        int         w;
        if (!reset) begin
            m_src[k] = -1; m_left[k] = 0; m_gap[k] = 1'b0;
            m_rr[k] = 0; m_prev[k] = 0; m_sel[k] = 0;
        end else if (m_src[k] >= 0) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
                m_gap[k]  = 1'b1;
                m_prev[k] = m_src[k];
                if (m_src[k] < 4) m_rr[k] = (m_src[k] + 1) % 4;
                m_src[k] = -1;
            end
        end else begin
            r = req;
            if (m_gap[k]) r[m_prev[k]] = 1'b0;
            m_gap[k] = 1'b0;
            w = pick(r, m_rr[k]);
            if (w >= 0) begin
                m_src[k]  = w;
                m_sel[k]  = w;
                m_left[k] = wc[k];
            end
        end
    endtask

    task automatic model_check(input int k, input logic [2:0] s, input logic rw,
                               input logic [4:0] g, input logic b);
        logic [4:0] eg;
        logic       erw;
        eg  = (m_src[k] >= 0) ? (5'b00001 << m_src[k]) : 5'd0;
        erw = (m_src[k] >= 0) && !(ZF && wr_addr == 5'd0);
        chk($sformatf("dut%0d.sel", k), 32'(s), 32'(m_sel[k]));
        chk($sformatf("dut%0d.grant", k), 32'(g), 32'(eg));
        chk($sformatf("dut%0d.reg_write", k), 32'(rw), 32'(erw));
        chk($sformatf("dut%0d.busy", k), 32'(b), 32'((m_src[k] >= 0) || m_gap[k]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        model_check(0, sel_a, rw_a, grant_a, busy_a);
        model_check(1, sel_b, rw_b, grant_b, busy_b);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = 5'd0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        int cnt;
        reset   = 1'b0;
        req     = 5'd0;
        wr_addr = 5'd5;

        do_reset();
        chk("reset.grant", 32'(grant_a), 32'd0);
        chk("reset.busy", 32'(busy_b), 32'd0);

        // Single request
        req = 5'b00010;
        step();
        chk("single.grant", 32'(grant_a), 32'b00010);
        chk("single.sel", 32'(sel_a), 32'd1);
        chk("single.rw", 32'(rw_a), 32'd1);
        req = 5'd0;
        step();
        chk("single.rel_grant", 32'(grant_a), 32'd0);
        chk("single.rel_busy", 32'(busy_a), 32'd1);
        step();
        chk("single.idle_busy", 32'(busy_a), 32'd0);
        repeat (3) step();

        // Round-robin between sources 0 and 2
        do_reset();
        req = 5'b00101;
        step();
        chk("rr.g1", 32'(grant_a), 32'b00001);
        step();
        chk("rr.gap", 32'(grant_a), 32'd0);
        step();
        chk("rr.g2", 32'(grant_a), 32'b00100);
        chk("rr.sel2", 32'(sel_a), 32'd2);
        step();
        step();
        chk("rr.g3", 32'(grant_a), 32'b00001);
        req = 5'd0;
        repeat (6) step();

        // Exception priority
        do_reset();
        req = 5'b11000;
        step();
        chk("exc.g1", 32'(grant_a), 32'b10000);
        chk("exc.sel1", 32'(sel_a), 32'd4);
        step();
        step();
        chk("exc.g2", 32'(grant_a), 32'b01000);
        chk("exc.sel2", 32'(sel_a), 32'd3);
        req = 5'd0;
        repeat (6) step();

        // Multi-cycle write with early request drop
        do_reset();
        req = 5'b01000;
        step();
        req = 5'd0;
        cnt = int'(rw_b);
        for (int i = 0; i < 5; i++) begin
            step();
            cnt += int'(rw_b);
        end
        chk("multi.rw_cycles", 32'(cnt), 32'd3);
        chk("multi.idle", 32'(busy_b), 32'd0);

        // Reset during the second write cycle
        do_reset();
        req = 5'b00001;
        step();
        step();
        reset = 1'b0;
        req   = 5'd0;
        step();
        chk("rstmid.grant", 32'(grant_b), 32'd0);
        chk("rstmid.rw", 32'(rw_b), 32'd0);
        chk("rstmid.busy", 32'(busy_b), 32'd0);
        reset = 1'b1;
        repeat (3) step();
        chk("rstmid.stay_idle", 32'(busy_b), 32'd0);

        // Write to $0
        do_reset();
        req     = 5'b00001;
        wr_addr = 5'd0;
        step();
        chk("zero.grant", 32'(grant_a), 32'b00001);
        chk("zero.rw", 32'(rw_a), ZF ? 32'd0 : 32'd1);
        req     = 5'd0;
        wr_addr = 5'd5;
        repeat (5) step();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            req     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom & $urandom);
            wr_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            reset   = ($urandom_range(0, 79) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
